// File: rtl/gpio_pin_ctrl_if.sv
// Register-file <-> pin-controller bundle: per-pin control fields in, pad drive and update fields out.
// master = register file / pad side, slave = gpio_pin_ctrl.
interface gpio_pin_ctrl_if #(
  parameter int GpioCount = 16
);
  logic [GpioCount-1:0] dir_i;
  logic [GpioCount-1:0] en_i;
  logic [GpioCount-1:0] out_i;
  logic [GpioCount-1:0] toggle_i;
  logic [GpioCount-1:0] intrpt_en_i;
  logic [GpioCount-1:0] intrpt_i;
  logic [GpioCount-1:0] intrpt_edge_i;
  logic [GpioCount-1:0] gpio_in_i;
  logic [GpioCount-1:0] gpio_out_o;
  logic [GpioCount-1:0] gpio_out_en_o;
  logic [GpioCount-1:0] sync_in_o;
  logic [GpioCount-1:0] out_o;
  logic [GpioCount-1:0] out_valid_o;
  logic [GpioCount-1:0] intrpt_o;
  logic [GpioCount-1:0] intrpt_valid_o;
  logic                 irq_o;

  modport master (
    output dir_i, en_i, out_i, toggle_i, intrpt_en_i, intrpt_i, intrpt_edge_i, gpio_in_i,
    input  gpio_out_o, gpio_out_en_o, sync_in_o, out_o, out_valid_o, intrpt_o, intrpt_valid_o, irq_o
  );

  modport slave (
    input  dir_i, en_i, out_i, toggle_i, intrpt_en_i, intrpt_i, intrpt_edge_i, gpio_in_i,
    output gpio_out_o, gpio_out_en_o, sync_in_o, out_o, out_valid_o, intrpt_o, intrpt_valid_o, irq_o
  );
endinterface

// File: rtl/gpio_pin_ctrl.sv
// Per-pin GPIO: 2-flop pad sync (+ debounce when GPIO_PIN_CTRL_DEBOUNCE_EN), edge interrupts 3 cycles after a pad change,
// toggle strobes 1 cycle after request, registered irq; no backpressure, every event is a one-cycle pulse.
module gpio_pin_ctrl #(
  parameter int GpioCount      = 16,
  parameter int DebounceCycles = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  gpio_pin_ctrl_if.slave bus
);

  if (DebounceCycles < 1 || DebounceCycles > 255) begin : g_bad_cfg
    $error("gpio_pin_ctrl: DebounceCycles must be in 1..255");
  end

  logic [GpioCount-1:0] s1;
  logic [GpioCount-1:0] s2;
  logic [GpioCount-1:0] filt;
  logic [GpioCount-1:0] prev;
  logic [GpioCount-1:0] tgl_pend;
  logic [GpioCount-1:0] evt_q;
  logic [GpioCount-1:0] rise;
  logic [GpioCount-1:0] fall;
  logic [GpioCount-1:0] evt;
  logic [1:0]           arm_cnt;
  logic                 armed;
  logic                 irq_q;

`ifdef GPIO_PIN_CTRL_DEBOUNCE_EN
  logic [7:0] db_cnt [GpioCount];

  // filt moves on the cycle the counter would reach DebounceCycles, giving 2+DebounceCycles total latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt <= '0;
      for (int i = 0; i < GpioCount; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GpioCount; i++) begin
        if (s2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 8'(DebounceCycles - 1)) begin
          filt[i]   <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign filt = s2;
`endif

  assign armed = (arm_cnt == 2'd3);
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;
  assign evt   = {GpioCount{armed}} & bus.en_i & ~bus.dir_i & bus.intrpt_en_i
               & ((bus.intrpt_edge_i & fall) | (~bus.intrpt_edge_i & rise));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      tgl_pend <= '0;
      evt_q    <= '0;
      arm_cnt  <= '0;
      irq_q    <= 1'b0;
    end else begin
      s1       <= bus.gpio_in_i;
      s2       <= s1;
      // prev follows filt unconditionally so re-enabling a pin never sees a stale edge
      prev     <= filt;
      tgl_pend <= bus.toggle_i;
      evt_q    <= evt;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      irq_q    <= |(bus.intrpt_i & bus.intrpt_en_i);
    end
  end

  assign bus.gpio_out_o     = bus.out_i;
  assign bus.gpio_out_en_o  = bus.en_i & bus.dir_i;
  assign bus.sync_in_o      = filt;
  assign bus.out_valid_o    = tgl_pend;
  assign bus.out_o          = bus.out_i ^ tgl_pend;
  assign bus.intrpt_valid_o = evt_q;
  assign bus.intrpt_o       = evt_q;
  assign bus.irq_o          = irq_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Directed bench for gpio_pin_ctrl: reset, sync latency, edge interrupts, toggles, irq, and debounce when GPIO_PIN_CTRL_DEBOUNCE_EN.
module tb_gpio_pin_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [15:0] acc;
  int   pulses;

  always #5 clk = ~clk;

  gpio_pin_ctrl_if #(.GpioCount(16)) bus ();

  gpio_pin_ctrl #(.GpioCount(16), .DebounceCycles(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // OR of every interrupt pulse seen over n cycles
  task automatic run_acc(input int n);
    acc = '0;
    repeat (n) begin
      tick();
      acc = acc | bus.intrpt_valid_o | bus.intrpt_o;
    end
  endtask

  initial begin
    bus.dir_i         = '0;
    bus.en_i          = 16'hFFFF;
    bus.out_i         = 16'h1234;
    bus.toggle_i      = '0;
    bus.intrpt_en_i   = 16'hFFFF;
    bus.intrpt_i      = '0;
    bus.intrpt_edge_i = '0;
    bus.gpio_in_i     = '0;

`ifdef GPIO_PIN_CTRL_DEBOUNCE_EN
    repeat (3) tick();
    check_eq("rst_sync", bus.sync_in_o, 16'h0);
    check_eq("rst_ivld", bus.intrpt_valid_o, 16'h0);
    check_eq("rst_irq", bus.irq_o, 1'b0);
    rst = 1'b0;
    repeat (6) tick();

    bus.gpio_in_i = 16'h0001;
    repeat (3) tick();
    bus.gpio_in_i = 16'h0000;
    acc = '0;
    repeat (12) begin
      tick();
      acc = acc | bus.intrpt_valid_o | bus.sync_in_o;
    end
    check_eq("glitch_suppressed", acc, 16'h0);

    bus.gpio_in_i = 16'h0001;
    pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 10) bus.gpio_in_i = 16'h0000;
      if (k == 5) check_eq("db_sync_k5", bus.sync_in_o[0], 1'b0);
      if (k == 6) check_eq("db_sync_k6", bus.sync_in_o[0], 1'b1);
      if (k == 7) check_eq("db_ivld_k7", bus.intrpt_valid_o, 16'h0001);
      if (k == 7) check_eq("db_intrpt_k7", bus.intrpt_o, 16'h0001);
      if (bus.intrpt_valid_o[0]) pulses++;
    end
    check_eq("db_one_pulse", pulses, 1);
    repeat (8) tick();
    check_eq("db_sync_low", bus.sync_in_o[0], 1'b0);
`else
    // pads all high through reset
    bus.gpio_in_i = 16'hFFFF;
    repeat (3) tick();
    check_eq("rst_sync", bus.sync_in_o, 16'h0);
    check_eq("rst_ivld", bus.intrpt_valid_o, 16'h0);
    check_eq("rst_intrpt", bus.intrpt_o, 16'h0);
    check_eq("rst_oval", bus.out_valid_o, 16'h0);
    check_eq("rst_irq", bus.irq_o, 1'b0);
    check_eq("rst_gpio_out", bus.gpio_out_o, 16'h1234);
    check_eq("rst_out_en0", bus.gpio_out_en_o, 16'h0);
    bus.dir_i = 16'h00F0;
    #1;
    check_eq("out_en_dir", bus.gpio_out_en_o, 16'h00F0);
    bus.dir_i = 16'h0;

    rst = 1'b0;
    tick();
    check_eq("sync_c1", bus.sync_in_o, 16'h0);
    tick();
    check_eq("sync_c2", bus.sync_in_o, 16'hFFFF);
    run_acc(8);
    check_eq("no_reset_edge", acc, 16'h0);

    // falling edges with rising selected: nothing
    bus.gpio_in_i = 16'h0;
    run_acc(5);
    check_eq("fall_ignored", acc, 16'h0);
    check_eq("sync_low", bus.sync_in_o, 16'h0);

    bus.gpio_in_i = 16'h0008;
    tick();
    check_eq("p3_c1", bus.intrpt_valid_o, 16'h0);
    tick();
    check_eq("p3_sync_c2", bus.sync_in_o, 16'h0008);
    check_eq("p3_c2", bus.intrpt_valid_o, 16'h0);
    tick();
    check_eq("p3_ivld_c3", bus.intrpt_valid_o, 16'h0008);
    check_eq("p3_intrpt_c3", bus.intrpt_o, 16'h0008);
    tick();
    check_eq("p3_c4", bus.intrpt_valid_o, 16'h0);
    bus.gpio_in_i = 16'h0;
    run_acc(5);
    check_eq("p3_fall", acc, 16'h0);

    // pin 5: falling-edge select, first as output
    bus.intrpt_edge_i = 16'h0020;
    bus.dir_i         = 16'h0020;
    #1;
    check_eq("p5_out_en", bus.gpio_out_en_o, 16'h0020);
    bus.gpio_in_i = 16'h0020;
    run_acc(5);
    check_eq("p5_rise_out", acc, 16'h0);
    bus.gpio_in_i = 16'h0;
    run_acc(5);
    check_eq("p5_fall_out", acc, 16'h0);
    bus.dir_i = 16'h0;
    bus.gpio_in_i = 16'h0020;
    run_acc(5);
    check_eq("p5_rise_in", acc, 16'h0);
    bus.gpio_in_i = 16'h0;
    tick();
    tick();
    check_eq("p5_c2", bus.intrpt_valid_o, 16'h0);
    tick();
    check_eq("p5_fall_in", bus.intrpt_valid_o, 16'h0020);
    tick();
    check_eq("p5_c4", bus.intrpt_valid_o, 16'h0);
    bus.intrpt_edge_i = 16'h0;

    // toggles
    bus.out_i    = 16'h00F0;
    bus.toggle_i = 16'h0011;
    tick();
    bus.toggle_i = 16'h0;
    check_eq("tgl_oval", bus.out_valid_o, 16'h0011);
    check_eq("tgl_out", bus.out_o, 16'h00E1);
    check_eq("tgl_pad", bus.gpio_out_o, 16'h00F0);
    tick();
    check_eq("tgl_oval_off", bus.out_valid_o, 16'h0);
    check_eq("tgl_out_off", bus.out_o, 16'h00F0);
    bus.toggle_i = 16'h0100;
    tick();
    check_eq("tgl_b2b_1", bus.out_valid_o, 16'h0100);
    tick();
    bus.toggle_i = 16'h0;
    check_eq("tgl_b2b_2", bus.out_valid_o, 16'h0100);
    check_eq("tgl_b2b_out", bus.out_o, 16'h01F0);
    tick();
    check_eq("tgl_b2b_end", bus.out_valid_o, 16'h0);

    // irq
    bus.intrpt_i = 16'h0080;
    tick();
    check_eq("irq_set", bus.irq_o, 1'b1);
    bus.intrpt_en_i = 16'hFF7F;
    tick();
    check_eq("irq_clr", bus.irq_o, 1'b0);
    bus.intrpt_i    = 16'h0;
    bus.intrpt_en_i = 16'hFFFF;

    // two pins at once, pin 15 disabled
    bus.en_i      = 16'h7FFF;
    bus.gpio_in_i = 16'h8001;
    repeat (3) tick();
    check_eq("multi_c3", bus.intrpt_valid_o, 16'h0001);
    tick();
    check_eq("multi_c4", bus.intrpt_valid_o, 16'h0);
    bus.en_i = 16'hFFFF;
    run_acc(5);
    check_eq("reenable_level", acc, 16'h0);
    bus.gpio_in_i = 16'h0003;
    repeat (3) tick();
    check_eq("multi2_c3", bus.intrpt_valid_o, 16'h0002);
    bus.gpio_in_i = 16'h0;
    run_acc(5);
    check_eq("multi_fall", acc, 16'h0);

    // reset with an edge in flight and a toggle requested
    bus.gpio_in_i = 16'h0002;
    tick();
    tick();
    rst          = 1'b1;
    bus.toggle_i = 16'h0002;
    tick();
    check_eq("mid_rst_ivld", bus.intrpt_valid_o, 16'h0);
    check_eq("mid_rst_oval", bus.out_valid_o, 16'h0);
    check_eq("mid_rst_sync", bus.sync_in_o, 16'h0);
    rst          = 1'b0;
    bus.toggle_i = 16'h0;
    tick();
    check_eq("post_rst_oval", bus.out_valid_o, 16'h0);
    run_acc(6);
    check_eq("post_rst_edge", acc, 16'h0);
    check_eq("post_rst_sync", bus.sync_in_o, 16'h0002);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_pin_ctrl.md
GPIO_PIN_CTRL -- requirements
Module: gpio_pin_ctrl

Interface
REQ-001 SHALL have parameter GpioCount, default 16, number of GPIO pins.
REQ-002 SHALL have parameter DebounceCycles, default 4, stable-cycle count for the debounce filter (range 1..255).
REQ-003 SHALL have port clk_i  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports dir_i, en_i, out_i, toggle_i, intrpt_en_i, intrpt_i, intrpt_edge_i  input  GpioCount each  per-pin register-file fields (dir 1 = output; intrpt_edge 0 = rising, 1 = falling).
REQ-006 SHALL have port gpio_in_i  input  GpioCount  asynchronous pad inputs.
REQ-007 SHALL have ports gpio_out_o, gpio_out_en_o  output  GpioCount  pad output value and output enable.
REQ-008 SHALL have ports sync_in_o, out_o, out_valid_o, intrpt_o, intrpt_valid_o  output  GpioCount  per-pin update fields back to the register file.
REQ-009 SHALL have port irq_o  output  1  combined interrupt line.

Function
REQ-010 Each pin SHALL pass gpio_in_i through a 2-flop synchronizer (s1, s2); s2 is the synchronized value.
REQ-011 The filtered value filt SHALL equal s2 without debounce; sync_in_o SHALL equal filt, so a pad change is visible 2 cycles later without debounce.
REQ-012 gpio_out_o SHALL equal out_i; gpio_out_en_o SHALL equal en_i & dir_i (combinational).
REQ-013 A prev flop per pin SHALL hold filt from the previous cycle; rise = filt & ~prev, fall = ~filt & prev.
REQ-014 An arm counter (2 bit, saturating at 3) SHALL count from reset; edge detection SHALL be masked until it reaches 3, which suppresses spurious edges from reset-time pad levels.
REQ-015 Edge event for pin i SHALL be armed & en_i & ~dir_i & intrpt_en_i & (intrpt_edge_i ? fall : rise).
REQ-016 An edge event SHALL drive intrpt_valid_o[i]=1 and intrpt_o[i]=1 for exactly that one cycle; otherwise both are 0.
REQ-017 Level alone SHALL never raise an interrupt; enabling intrpt_en_i while the pin is already high gives no event.
REQ-018 prev SHALL track filt regardless of en/dir/intrpt_en, so re-enabling does not generate a stale edge.
REQ-019 toggle_i[i] sampled high SHALL register a pending toggle; the next cycle SHALL drive out_valid_o[i]=1 and out_o[i]=~out_i[i] (value of out_i in that cycle); otherwise out_valid_o[i]=0 and out_o[i]=out_i[i].
REQ-020 Toggle pulses on consecutive cycles SHALL each produce one out_valid_o pulse (no merging or dropping).
REQ-021 irq_o SHALL be registered: irq_o(t+1) = OR over i of (intrpt_i[i] & intrpt_en_i[i]) at t.
REQ-022 Pins are independent; simultaneous events on multiple pins SHALL all be reported in the same cycle.

Reset
REQ-023 While rst_i is high at a clock edge, s1, s2, prev, filt, debounce counters, toggle pending, arm counter and irq_o SHALL clear to 0.
REQ-024 Consequently, after reset: out_valid_o=0, intrpt_valid_o=0, intrpt_o=0, sync_in_o=0 and irq_o=0; gpio_out_o and gpio_out_en_o follow inputs.
REQ-025 Reset asserted mid-debounce or with a toggle pending SHALL discard that state; no pulse emerges after reset release.

Configuration
REQ-026 Macro GPIO_PIN_CTRL_DEBOUNCE_EN SHALL enable a per-pin debounce filter when defined.
REQ-027 When defined: a per-pin counter increments while s2 != filt; it clears when s2 == filt. When it reaches DebounceCycles, filt <= s2 and the counter clears.
REQ-028 Debounce latency: a stable pad change SHALL reach sync_in_o 2+DebounceCycles cycles after the pad change. Glitches shorter than DebounceCycles SHALL produce no filt change and no interrupt.
REQ-029 When not defined: no counters are instantiated and filt=s2 combinationally.

Verification
REQ-030 Reset, gpio_in_i=all 1 held, intrpt_en=1, en=1, dir=0, edge=0 -> no intrpt_valid_o pulse ever; sync_in_o=0xFFFF from cycle 2 after release.
REQ-031 Pin 3 input, rising enabled, gpio_in_i[3] 0->1 (no debounce) -> intrpt_valid_o[3]=intrpt_o[3]=1 for exactly one cycle, 3 cycles after the change; falling edge gives no pulse.
REQ-032 intrpt_edge[5]=1, dir[5]=1 (output), pad 5 falls -> no event; set dir[5]=0, pad 5 falls again -> one pulse.
REQ-033 out_i=0x00F0, toggle_i=0x0011 for one cycle -> next cycle out_valid_o=0x0011, out_o=0x00E1; following cycle out_valid_o=0.
REQ-034 intrpt_i[7]=1, intrpt_en_i[7]=1 -> irq_o=1 one cycle later; clear intrpt_en_i[7] -> irq_o=0 one cycle later.
REQ-035 With GPIO_PIN_CTRL_DEBOUNCE_EN and DebounceCycles=4: a 3-cycle high glitch on pin 0 -> sync_in_o[0] stays 0 with no interrupt; a 10-cycle high -> sync_in_o[0]=1 at cycle 6 and one rising-edge pulse.
